axi_i2c_write_master: RTL and testbench

- Downstream stage of axi_write_channel_slave in the AXI-to-I2C bridge.
- Consumes one captured write (AWADDROUT/WDATAOUT pair) per command and serialises it as an I2C write frame: START, 7-bit device address + W, register byte, DATA_BYTES data bytes, STOP.
- Returns an AXI-coded status that the slave uses to drive BRESP.
- Single-master, open-drain bus.
- No clock stretching and no arbitration-loss detection.

---
 rtl/axi_i2c_pkg.sv | 25 ++
 rtl/axi_i2c_write_master_if.sv | 29 ++
 rtl/i2c_phase_timer.sv | 38 +++
 rtl/axi_i2c_write_master.sv | 163 ++++++++++++++++
 tb/tb_axi_i2c_write_master.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_i2c_pkg.sv
// Shared types and constants for the AXI-to-I2C write master.
package axi_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        DATA,
        DATA_ACK,
        STOP,
        RESP
    } i2c_wr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic I2C_WRITE = 1'b0;

    localparam int DEV_LSB = 0;
    localparam int REG_LSB = 8;

endpackage

// File: rtl/axi_i2c_write_master_if.sv
// Command/response handshake plus open-drain I2C pin controls for the write master.
interface axi_i2c_write_master_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WDATA_WIDTH = 32
);
    logic                   CMD_VALID;
    logic                   CMD_READY;
    logic [ADDR_WIDTH-1:0]  CMD_ADDR;
    logic [WDATA_WIDTH-1:0] CMD_DATA;
    logic                   RSP_VALID;
    logic                   RSP_READY;
    logic [1:0]             RSP_CODE;
    logic                   SCL_OE;
    logic                   SDA_OE;
    logic                   SDA_I;
    logic                   BUSY;

    // master: the I2C write engine; slave: the upstream AXI slave and the bus side
    modport master (
        input  CMD_VALID, CMD_ADDR, CMD_DATA, RSP_READY, SDA_I,
        output CMD_READY, RSP_VALID, RSP_CODE, SCL_OE, SDA_OE, BUSY
    );

    modport slave (
        output CMD_VALID, CMD_ADDR, CMD_DATA, RSP_READY, SDA_I,
        input  CMD_READY, RSP_VALID, RSP_CODE, SCL_OE, SDA_OE, BUSY
    );

endinterface

// File: rtl/i2c_phase_timer.sv
// Divides a slot into four phases of CLK_DIV cycles; restarts on start, holds when not running.
module i2c_phase_timer #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run,
    output logic [1:0] phase,
    output logic       phase_end,
    output logic       slot_end
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (start) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (run) begin
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
                phase   <= phase + 2'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    assign phase_end = (div_cnt == DIV_MAX);
    assign slot_end  = phase_end && (phase == 2'd3);

endmodule

// File: rtl/axi_i2c_write_master.sv
// Serialises one captured AXI write as an I2C write frame and returns an AXI-coded status.
module axi_i2c_write_master
    import axi_i2c_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int WDATA_WIDTH = 32,
    parameter int DATA_BYTES  = 4,
    parameter int CLK_DIV     = 125
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    axi_i2c_write_master_if.master bus
);
    localparam int DATA_W    = (DATA_BYTES * 8 <= WDATA_WIDTH) ? DATA_BYTES * 8 : WDATA_WIDTH;
    localparam int ADDR_KEEP = (ADDR_WIDTH < 16) ? ADDR_WIDTH : 16;
    localparam int BC_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [BC_W-1:0] BYTE_MAX = BC_W'(DATA_BYTES - 1);

    i2c_wr_state_t    state;
    logic [15:0]      addr_lat;
    logic [DATA_W-1:0] data_lat;
    logic [2:0]       bit_cnt;
    logic [BC_W-1:0]  byte_cnt;
    logic             nack;
    logic             cmd_ready;
    logic             rsp_valid;
    logic [1:0]       rsp_code;
    logic             scl_oe;
    logic             sda_oe;

    logic             accept;
    logic             running;
    logic [1:0]       phase;
    logic             phase_end;
    logic             slot_end;
    logic [7:0]       tx_byte;
    logic             tx_bit;
    logic             scl_next;
    logic             sda_next;

    assign accept  = (state == IDLE) && cmd_ready && bus.CMD_VALID;
    assign running = (state != IDLE) && (state != RESP);

    i2c_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk      (ACLK),
        .rst      (ARESET),
        .start    (accept),
        .run      (running),
        .phase    (phase),
        .phase_end(phase_end),
        .slot_end (slot_end)
    );

    always_comb begin
        tx_byte = {addr_lat[DEV_LSB +: 7], I2C_WRITE};
        case (state)
            REG:     tx_byte = addr_lat[REG_LSB +: 8];
            DATA:    tx_byte = data_lat[{byte_cnt, 3'b000} +: 8];
            default: ;
        endcase
        tx_bit = tx_byte[~bit_cnt];
    end

    // Pin levels for the current phase; registered below, so the bus trails the FSM by one cycle.
    always_comb begin
        scl_next = 1'b0;
        sda_next = 1'b0;
        case (state)
            START: sda_next = phase[1];
            ADDR, REG, DATA: begin
                scl_next = ~phase[1];
                sda_next = ~tx_bit;
            end
            ADDR_ACK, REG_ACK, DATA_ACK: scl_next = ~phase[1];
            STOP: begin
                scl_next = (phase == 2'd0);
                sda_next = ~phase[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            addr_lat  <= '0;
            data_lat  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            nack      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_code  <= RESP_OKAY;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            scl_oe <= scl_next;
            sda_oe <= sda_next;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        state     <= START;
                        cmd_ready <= 1'b0;
                        nack      <= 1'b0;
                        addr_lat  <= 16'(bus.CMD_ADDR[ADDR_KEEP-1:0]);
                        data_lat  <= bus.CMD_DATA[DATA_W-1:0];
                        bit_cnt   <= '0;
                        byte_cnt  <= BYTE_MAX;
                    end
                end
                START: if (slot_end) state <= ADDR;
                ADDR, REG, DATA: begin
                    if (slot_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= (state == ADDR) ? ADDR_ACK :
                                     (state == REG)  ? REG_ACK  : DATA_ACK;
                        end
                    end
                end
                ADDR_ACK, REG_ACK, DATA_ACK: begin
                    // The slave's ACK is taken at the end of P2, well inside SCL high.
                    if (phase_end && (phase == 2'd2) && bus.SDA_I) nack <= 1'b1;
                    if (slot_end) begin
                        if (nack) begin
                            state <= STOP;
                        end else if (state == ADDR_ACK) begin
                            state <= REG;
                        end else if (state == REG_ACK) begin
                            state <= DATA;
                        end else if (byte_cnt == '0) begin
                            state <= STOP;
                        end else begin
                            byte_cnt <= byte_cnt - BC_W'(1);
                            state    <= DATA;
                        end
                    end
                end
                STOP: if (slot_end) state <= RESP;
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_code  <= nack ? RESP_SLVERR : RESP_OKAY;
                    end else if (bus.RSP_READY) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CMD_READY = cmd_ready;
    assign bus.RSP_VALID = rsp_valid;
    assign bus.RSP_CODE  = rsp_code;
    assign bus.SCL_OE    = scl_oe;
    assign bus.SDA_OE    = sda_oe;
    assign bus.BUSY      = (state != IDLE);

endmodule

// File: tb/tb_axi_i2c_write_master.sv
// Scoreboard bench: stimulus queues expected bytes/responses, a bus-level monitor decodes and compares.
module tb_axi_i2c_write_master;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic slavePull = 1'b0;
    logic ignoreBus = 1'b0;
    int   nackIndex = -1;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int acceptCyc = 0;
    int hsCyc = 0;
    int hsCount = 0;

    logic [7:0] expByteQ[$];
    int         expCntQ[$];
    int         expLatQ[$];
    logic [1:0] expCodeQ[$];

    axi_i2c_write_master_if #(.ADDR_WIDTH(32), .WDATA_WIDTH(32)) bus ();

    axi_i2c_write_master #(
        .ADDR_WIDTH (32),
        .WDATA_WIDTH(32),
        .DATA_BYTES (4),
        .CLK_DIV    (2)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus)
    );

    // Wired-AND of the master's open-drain output and the modelled slave.
    assign bus.SDA_I = ~(bus.SDA_OE | slavePull);

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Bus and response monitor
    logic       prevScl = 1'b1;
    logic       prevSda = 1'b1;
    logic       inFrame = 1'b0;
    int         bitN = 0;
    int         frameBytes = 0;
    logic [7:0] shiftReg = '0;
    logic       prevRspValid = 1'b0;
    logic [1:0] heldCode = '0;
    logic       hsPending = 1'b0;

    always @(negedge ACLK) begin
        logic scl;
        logic sda;
        scl = ~bus.SCL_OE;
        sda = bus.SDA_I;
        if (ignoreBus || ARESET) begin
            inFrame   = 1'b0;
            slavePull = 1'b0;
        end else if (prevScl && scl && prevSda && !sda) begin
            inFrame    = 1'b1;
            bitN       = 0;
            frameBytes = 0;
        end else if (prevScl && scl && !prevSda && sda && inFrame) begin
            inFrame = 1'b0;
            if (expCntQ.size() == 0) failNow("unexpected_stop");
            else checkOutput("frame_byte_count", frameBytes, expCntQ.pop_front());
        end else if (!prevScl && scl && inFrame) begin
            if (bitN < 8) begin
                shiftReg = {shiftReg[6:0], sda};
                bitN++;
                if (bitN == 8) begin
                    if (expByteQ.size() == 0) failNow("unexpected_byte");
                    else checkOutput("i2c_byte", {24'h0, shiftReg}, {24'h0, expByteQ.pop_front()});
                    frameBytes++;
                end
            end else begin
                bitN = 0;
            end
        end else if (prevScl && !scl && inFrame) begin
            slavePull = (bitN == 8) && ((frameBytes - 1) != nackIndex);
        end
        prevScl = scl;
        prevSda = sda;

        if (!ARESET) begin
            if (bus.CMD_VALID && bus.CMD_READY) acceptCyc = cyc + 1;
            if (hsPending) begin
                checkOutput("cmd_ready_after_hs", {31'h0, bus.CMD_READY}, 32'h1);
                checkOutput("rsp_valid_after_hs", {31'h0, bus.RSP_VALID}, 32'h0);
                hsPending = 1'b0;
            end
            if (bus.RSP_VALID && !prevRspValid) begin
                if (expLatQ.size() == 0) begin
                    failNow("unexpected_response");
                end else begin
                    checkOutput("rsp_latency", cyc - acceptCyc, expLatQ.pop_front());
                    checkOutput("rsp_code", {30'h0, bus.RSP_CODE}, {30'h0, expCodeQ.pop_front()});
                end
            end else if (bus.RSP_VALID && prevRspValid) begin
                checkOutput("rsp_code_hold", {30'h0, bus.RSP_CODE}, {30'h0, heldCode});
                checkOutput("cmd_ready_in_resp", {31'h0, bus.CMD_READY}, 32'h0);
            end
            if (bus.RSP_VALID && bus.RSP_READY) begin
                hsPending = 1'b1;
                hsCyc     = cyc + 1;
                hsCount++;
            end
        end
        heldCode     = bus.RSP_CODE;
        prevRspValid = bus.RSP_VALID;
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input int nack,
                                 input logic [47:0] bytes, input int nBytes, input int lat,
                                 input logic [1:0] code);
        bit accepted;
        nackIndex = nack;
        for (int i = 0; i < nBytes; i++) expByteQ.push_back(bytes[47 - 8 * i -: 8]);
        expCntQ.push_back(nBytes);
        expLatQ.push_back(lat);
        expCodeQ.push_back(code);
        bus.CMD_ADDR  = addr;
        bus.CMD_DATA  = data;
        bus.CMD_VALID = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge ACLK);
            if (bus.CMD_READY) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) failNow("accept_timeout");
        @(posedge ACLK);
        #1 bus.CMD_VALID = 1'b0;
    endtask

    task automatic waitResponse(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge ACLK);
            if (hsCount >= target) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) failNow("response_timeout");
        #1;
    endtask

    initial begin
        bit seen;
        bus.CMD_VALID = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_DATA  = '0;
        bus.RSP_READY = 1'b1;

        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("reset_cmd_ready", {31'h0, bus.CMD_READY}, 32'h0);
        checkOutput("reset_rsp_valid", {31'h0, bus.RSP_VALID}, 32'h0);
        checkOutput("reset_rsp_code", {30'h0, bus.RSP_CODE}, 32'h0);
        checkOutput("reset_scl_oe", {31'h0, bus.SCL_OE}, 32'h0);
        checkOutput("reset_sda_oe", {31'h0, bus.SDA_OE}, 32'h0);
        checkOutput("reset_busy", {31'h0, bus.BUSY}, 32'h0);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1 checkOutput("cmd_ready_after_release", {31'h0, bus.CMD_READY}, 32'h1);

        $display("[TB] full frame, all ACKed");
        applyStimulus(32'h0000_AB50, 32'h1234_5678, -1, 48'hA0AB_1234_5678, 6, 449, 2'b00);
        waitResponse(1);
        checkOutput("busy_after_frame", {31'h0, bus.BUSY}, 32'h0);

        $display("[TB] NACK on address");
        applyStimulus(32'h0000_AB50, 32'h1234_5678, 0, 48'hA000_0000_0000, 1, 89, 2'b10);
        waitResponse(2);

        $display("[TB] NACK on third data byte");
        applyStimulus(32'h0000_AB50, 32'h1234_5678, 4, 48'hA0AB_1234_5600, 5, 377, 2'b10);
        waitResponse(3);

        $display("[TB] response back-pressure");
        bus.RSP_READY = 1'b0;
        applyStimulus(32'hFFFF_0733, 32'h00FF_A55A, -1, 48'h6607_00FF_A55A, 6, 449, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge ACLK);
            if (bus.RSP_VALID) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) failNow("rsp_valid_timeout");
        repeat (5) @(posedge ACLK);
        #1;
        bus.CMD_ADDR  = 32'h0000_1111;
        bus.CMD_DATA  = 32'h2222_2222;
        bus.CMD_VALID = 1'b1;
        @(posedge ACLK);
        #1 bus.CMD_VALID = 1'b0;
        repeat (14) @(posedge ACLK);
        #1 bus.RSP_READY = 1'b1;
        waitResponse(4);
        repeat (3) @(posedge ACLK);
        #1 checkOutput("busy_after_ignored_cmd", {31'h0, bus.BUSY}, 32'h0);

        $display("[TB] reset during DATA");
        applyStimulus(32'h0000_AB50, 32'h1234_5678, -1, 48'hA0AB_1234_5678, 6, 449, 2'b00);
        repeat (250) @(posedge ACLK);
        #1 checkOutput("busy_mid_frame", {31'h0, bus.BUSY}, 32'h1);
        ignoreBus = 1'b1;
        ARESET = 1'b1;
        #1;
        checkOutput("abort_scl_oe", {31'h0, bus.SCL_OE}, 32'h0);
        checkOutput("abort_sda_oe", {31'h0, bus.SDA_OE}, 32'h0);
        checkOutput("abort_rsp_valid", {31'h0, bus.RSP_VALID}, 32'h0);
        checkOutput("abort_busy", {31'h0, bus.BUSY}, 32'h0);
        checkOutput("abort_cmd_ready", {31'h0, bus.CMD_READY}, 32'h0);
        expByteQ.delete();
        expCntQ.delete();
        expLatQ.delete();
        expCodeQ.delete();
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ignoreBus = 1'b0;
        applyStimulus(32'h0000_3C2A, 32'hDEAD_BEEF, -1, 48'h543C_DEAD_BEEF, 6, 449, 2'b00);
        waitResponse(5);

        $display("[TB] back-to-back commands");
        applyStimulus(32'h0000_AB50, 32'h1234_5678, -1, 48'hA0AB_1234_5678, 6, 449, 2'b00);
        applyStimulus(32'h0000_3C2A, 32'hDEAD_BEEF, -1, 48'h543C_DEAD_BEEF, 6, 449, 2'b00);
        checkOutput("b2b_accept_gap", acceptCyc - hsCyc, 1);
        waitResponse(7);
        repeat (4) @(posedge ACLK);
        checkOutput("leftover_bytes", expByteQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
